// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath and pipeline_ctrl.
// The exception pins exist only when PIPE_CTRL_EXC_EN is defined.
interface pipeline_ctrl_if #(
   parameter int REG_AW = 5
);
   logic              pc_jump_en;
   logic              ex_mem_rd;
   logic [REG_AW-1:0] ex_wd;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_rs_used;
   logic              id_rt_used;
   logic              md_start;
   logic              mem_stall;
   logic [4:0]        stall;
   logic [4:0]        flush;
   logic              md_done;
   logic              busy;
`ifdef PIPE_CTRL_EXC_EN
   logic              exc_req;
   logic              exc_pc_load;

   modport master (
      input  pc_jump_en, ex_mem_rd, ex_wd, id_rs, id_rt, id_rs_used, id_rt_used,
             md_start, mem_stall, exc_req,
      output stall, flush, md_done, busy, exc_pc_load
   );
   modport slave (
      output pc_jump_en, ex_mem_rd, ex_wd, id_rs, id_rt, id_rs_used, id_rt_used,
             md_start, mem_stall, exc_req,
      input  stall, flush, md_done, busy, exc_pc_load
   );
`else
   modport master (
      input  pc_jump_en, ex_mem_rd, ex_wd, id_rs, id_rt, id_rs_used, id_rt_used,
             md_start, mem_stall,
      output stall, flush, md_done, busy
   );
   modport slave (
      output pc_jump_en, ex_mem_rd, ex_wd, id_rs, id_rt, id_rs_used, id_rt_used,
             md_start, mem_stall,
      input  stall, flush, md_done, busy
   );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; bit order [0]PC..[4]MEM/WB.
// Optional MEM-stage exception path enabled by defining PIPE_CTRL_EXC_EN.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no multi-cycle op in EX; md_start here is occupancy cycle 1
//  MD_BUSY | mul/div occupying EX; cnt = remaining stall cycles before done
module pipeline_ctrl #(
   parameter int REG_AW    = 5,
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.master pc
);
   typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [REG_AW-1:0] ex_wd;
   logic              load_use;
   logic              exc_hit;

   assign ex_wd    = pc.ex_wd;
   assign load_use = pc.ex_mem_rd && (ex_wd != '0) &&
                     (((ex_wd == pc.id_rs) && pc.id_rs_used) ||
                      ((ex_wd == pc.id_rt) && pc.id_rt_used));
`ifdef PIPE_CTRL_EXC_EN
   assign exc_hit  = pc.exc_req;
`else
   assign exc_hit  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (exc_hit) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (!pc.mem_stall) begin
         case (state)
            IDLE: begin
               if (pc.md_start) begin
                  state <= MD_BUSY;
                  cnt   <= CNT_W'(MD_CYCLES - 2);
               end
            end
            MD_BUSY: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output priority: exception > mem wait > mul/div > load-use > jump.
   always_comb begin
      pc.stall   = 5'b00000;
      pc.flush   = 5'b00000;
      pc.md_done = 1'b0;
      pc.busy    = rst && (state == MD_BUSY);
      if (!rst) begin
         pc.busy = 1'b0;
      end else if (exc_hit) begin
         pc.flush = 5'b11110;
      end else if (pc.mem_stall) begin
         pc.stall = 5'b01111;
         pc.flush = 5'b10000;
      end else if (((state == IDLE) && pc.md_start) ||
                   ((state == MD_BUSY) && (cnt != '0))) begin
         pc.stall = 5'b00111;
         pc.flush = 5'b01000;
      end else if (state == MD_BUSY) begin
         pc.md_done = 1'b1;
      end else if (load_use) begin
         // Jump is dropped here: the branch stays in ID and re-resolves.
         pc.stall = 5'b00011;
         pc.flush = 5'b00100;
      end else if (pc.pc_jump_en) begin
         pc.flush = 5'b00010;
      end
   end

`ifdef PIPE_CTRL_EXC_EN
   assign pc.exc_pc_load = rst && pc.exc_req;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against an occupancy-count reference model.
// Exception checks are included when PIPE_CTRL_EXC_EN is defined.
module tb_pipeline_ctrl;
   localparam int REG_AW    = 5;
   localparam int MD_CYCLES = 4;
   localparam int CNT_W     = 6;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   // reference: is a mul/div occupying EX, and how many occupancy cycles remain
   bit   md_active;
   int   md_left;
   logic exc_in;

   pipeline_ctrl_if #(.REG_AW(REG_AW)) bus ();

   pipeline_ctrl #(.REG_AW(REG_AW), .MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .pc  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic drive(input bit r, input bit jmp, input bit ld, input int wd,
                        input int rs, input int rt, input bit rsu, input bit rtu,
                        input bit mds, input bit ms, input bit exc);
      @(negedge clk);
      rst            = r;
      bus.pc_jump_en = jmp;
      bus.ex_mem_rd  = ld;
      bus.ex_wd      = REG_AW'(wd);
      bus.id_rs      = REG_AW'(rs);
      bus.id_rt      = REG_AW'(rt);
      bus.id_rs_used = rsu;
      bus.id_rt_used = rtu;
      bus.md_start   = mds;
      bus.mem_stall  = ms;
      exc_in         = exc;
`ifdef PIPE_CTRL_EXC_EN
      bus.exc_req    = exc;
`endif
   endtask

   // Check this cycle's outputs against the model, then advance the model at the edge.
   task automatic step();
      logic [4:0] es, ef;
      logic       ed, eb, ee;
      bit         lu, exc;
      #1;
`ifdef PIPE_CTRL_EXC_EN
      exc = exc_in;
`else
      exc = 1'b0;
`endif
      lu = bus.ex_mem_rd && (bus.ex_wd != 0) &&
           ((bus.ex_wd == bus.id_rs && bus.id_rs_used) ||
            (bus.ex_wd == bus.id_rt && bus.id_rt_used));
      es = 5'b0; ef = 5'b0; ed = 1'b0; ee = 1'b0;
      eb = rst && md_active;
      if (!rst) begin
      end else if (exc) begin
         ef = 5'b11110; ee = 1'b1;
      end else if (bus.mem_stall) begin
         es = 5'b01111; ef = 5'b10000;
      end else if (md_active && md_left > 1) begin
         es = 5'b00111; ef = 5'b01000;
      end else if (md_active) begin
         ed = 1'b1;
      end else if (bus.md_start) begin
         es = 5'b00111; ef = 5'b01000;
      end else if (lu) begin
         es = 5'b00011; ef = 5'b00100;
      end else if (bus.pc_jump_en) begin
         ef = 5'b00010;
      end
      chk("stall",   8'(bus.stall),   8'(es));
      chk("flush",   8'(bus.flush),   8'(ef));
      chk("md_done", 8'(bus.md_done), 8'(ed));
      chk("busy",    8'(bus.busy),    8'(eb));
`ifdef PIPE_CTRL_EXC_EN
      chk("exc_pc_load", 8'(bus.exc_pc_load), 8'(ee));
`endif
      @(posedge clk);
      if (!rst || exc) begin
         md_active = 1'b0;
      end else if (!bus.mem_stall) begin
         if (md_active) begin
            if (md_left > 1) md_left--;
            else             md_active = 1'b0;
         end else if (bus.md_start) begin
            md_active = 1'b1;
            md_left   = MD_CYCLES - 1;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit jmp, input bit ld, input int wd,
                      input int rs, input int rt, input bit rsu, input bit rtu,
                      input bit mds, input bit ms, input bit exc);
      drive(r, jmp, ld, wd, rs, rt, rsu, rtu, mds, ms, exc);
      step();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      md_active = 1'b0; md_left = 0;
      // reset, outputs must be zero even with requests present
      cyc(0, 1, 1, 5, 5, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // load-use on rs, then the same with ex_wd=0
      drive(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
      #1 chk("lu_stall_const", 8'(bus.stall), 8'b00011);
      step();
      cyc(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      // single jump, then quiet
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // mul/div with md_start held: 3 stall cycles then done
      for (int i = 0; i < MD_CYCLES; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // mul/div reaching cnt=1, then 3 mem_stall cycles
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1 chk("md_done_const", 8'(bus.md_done), 8'd1);
      step();
      // jump together with load-use on rt
      drive(1, 1, 1, 7, 0, 7, 0, 1, 0, 0, 0);
      #1 chk("jmp_lu_flush_const", 8'(bus.flush), 8'b00100);
      step();
      // reset while busy
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_EXC_EN
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 49) != 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 29) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
